// File: rtl/rr_arbiter8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// The search result struct carries a found flag alongside the winning index.
package rr_arbiter8_pkg;
  localparam int ARB_N        = 8;
  localparam int ARB_IDX_W    = 3;
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } pick_t;
endpackage

// File: rtl/rr_arbiter8_dec3x8.sv
// 3-to-8 one-hot decoder with enable; output is all zero when disabled.
module dec3x8
  import rr_arbiter8_pkg::*;
(
  input  logic [ARB_IDX_W-1:0] sel,
  input  logic                 enable,
  output logic [ARB_N-1:0]     out
);
  always_comb begin
    out = '0;
    if (enable) out[sel] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one single-owner resource shared by 8 requesters.
// Registered winner index is decoded to a one-hot grant; HOLD_MAX bounds ownership.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     gnt,
  output logic [ARB_IDX_W-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic                 timeout
);

  // Lowest rotated offset from start wins; descending loop lets it overwrite.
  function automatic pick_t rr_pick(input logic [ARB_N-1:0] r,
                                    input logic [ARB_IDX_W-1:0] start);
    pick_t                p;
    logic [ARB_IDX_W-1:0] idx;
    p = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      idx = start + ARB_IDX_W'(i);
      if (r[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  state_t               state, state_n;
  logic [ARB_IDX_W-1:0] ptr, ptr_n, id_n;
  logic [CNT_W-1:0]     hold_cnt, cnt_n;
  logic                 to_n;
  logic [ARB_N-1:0]     mask;
  logic                 owner_req, hold_hit;
  pick_t                pick;

  assign gnt_valid = (state == GRANT);
  assign owner_req = req[gnt_id];
  assign hold_hit  = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    mask = '0;
    // The outgoing owner never wins the handover search, even when revoked.
    if (state == GRANT) mask[gnt_id] = 1'b1;
  end

  assign pick = rr_pick(req & ~mask, ptr);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    id_n    = gnt_id;
    cnt_n   = hold_cnt;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (pick.found) begin
          state_n = GRANT;
          id_n    = pick.idx;
          ptr_n   = pick.idx + 3'd1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!owner_req || hold_hit) begin
          // A release on the revoke cycle wins: no timeout pulse then.
          to_n  = owner_req;
          cnt_n = '0;
          if (pick.found) begin
            id_n  = pick.idx;
            ptr_n = pick.idx + 3'd1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt_id   <= id_n;
      hold_cnt <= cnt_n;
      timeout  <= to_n;
    end
  end

  dec3x8 u_dec (
    .sel    (gnt_id),
    .enable (gnt_valid),
    .out    (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: vector table and corner sequences on two instances
// (HOLD_MAX=16 and HOLD_MAX=4), then random traffic against an ownership model.
module tb_rr_arbiter8;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [7:0] req_a, req_b, gnt_a, gnt_b;
  logic [2:0] id_a, id_b;
  logic       v_a, v_b, to_a, to_b;

  int errors = 0;
  int checks = 0;

  rr_arbiter8 #(.HOLD_MAX(16), .CNT_W(5)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .gnt(gnt_a),
    .gnt_id(id_a), .gnt_valid(v_a), .timeout(to_a));

  rr_arbiter8 #(.HOLD_MAX(4), .CNT_W(3)) dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .gnt(gnt_b),
    .gnt_id(id_b), .gnt_valid(v_b), .timeout(to_b));

  typedef struct {
    bit         dut;
    bit         rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    bit         v;
    bit         to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit d, bit rst, logic [7:0] rq, logic [7:0] g,
                              logic [2:0] id, bit v, bit to);
    vec_t r;
    r.dut = d; r.rst = rst; r.req = rq; r.gnt = g; r.id = id; r.v = v; r.to = to;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t r, input string tag);
    logic [7:0] g;
    logic [2:0] id;
    logic       v, to;
    if (r.dut) begin
      rst_b = r.rst; req_b = r.req; rst_a = 1'b1; req_a = '0;
    end else begin
      rst_a = r.rst; req_a = r.req; rst_b = 1'b1; req_b = '0;
    end
    @(posedge clk); #1;
    g  = r.dut ? gnt_b : gnt_a;
    id = r.dut ? id_b  : id_a;
    v  = r.dut ? v_b   : v_a;
    to = r.dut ? to_b  : to_a;
    chk({tag, " gnt"}, g, r.gnt);
    chk({tag, " valid"}, 8'(v), 8'(r.v));
    chk({tag, " timeout"}, 8'(to), 8'(r.to));
    if (r.v || r.rst) chk({tag, " gnt_id"}, 8'(id), 8'(r.id));
  endtask

  // Reference model: owner (-1 = none), search pointer, cycles owned so far.
  int m_own[2], m_ptr[2], m_age[2];
  bit m_to[2];
  int m_hmax[2] = '{16, 4};

  function automatic int rr_search(int start, logic [7:0] r, int excl);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (start + k) % 8;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input int d, input bit rst, input logic [7:0] r);
    int w;
    m_to[d] = 1'b0;
    if (rst) begin
      m_own[d] = -1; m_ptr[d] = 0; m_age[d] = 0;
    end else if (m_own[d] < 0) begin
      w = rr_search(m_ptr[d], r, -1);
      if (w >= 0) begin m_own[d] = w; m_ptr[d] = (w + 1) % 8; m_age[d] = 1; end
    end else if (!r[m_own[d]] || (m_hmax[d] != 0 && m_age[d] == m_hmax[d])) begin
      m_to[d] = r[m_own[d]];
      w = rr_search(m_ptr[d], r, m_own[d]);
      m_own[d] = w;
      m_age[d] = 1;
      if (w >= 0) m_ptr[d] = (w + 1) % 8;
    end else begin
      m_age[d]++;
    end
  endtask

  task automatic cmp_model(input int d, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic to);
    string t;
    logic [7:0] eg;
    t  = (d == 0) ? "rnd16" : "rnd4";
    eg = (m_own[d] >= 0) ? 8'(1 << m_own[d]) : 8'h00;
    chk({t, " gnt"}, g, eg);
    chk({t, " valid"}, 8'(v), 8'(m_own[d] >= 0));
    chk({t, " timeout"}, 8'(to), 8'(m_to[d]));
    if (m_own[d] >= 0) chk({t, " gnt_id"}, 8'(id), 8'(m_own[d]));
  endtask

  initial begin
    logic [7:0] cur;
    bit         rr;
    rst_a = 1'b1; rst_b = 1'b1; req_a = '0; req_b = '0;

    // Reset with all requests high, then idle.
    tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 3'd0, 0, 0));
    // Single requester 3, held then dropped.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 8'h08, 8'h08, 3'd3, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 3'd0, 0, 0));
    // Fairness: each owner keeps 2 cycles then drops its bit once.
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 8'h01, 3'd0, 1, 0));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(0, 0, 8'hFF, 8'(1 << i), 3'(i), 1, 0));
      tbl.push_back(mk(0, 0, 8'hFF & ~8'(1 << i), 8'(1 << ((i + 1) % 8)),
                       3'((i + 1) % 8), 1, 0));
    end
    // Wrap: owner 7 releases, pointer wraps to 0; 7 re-raised waits its turn.
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 3'd0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h80, 8'h80, 3'd7, 1, 0));
    tbl.push_back(mk(0, 0, 8'h01, 8'h01, 3'd0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h81, 8'h01, 3'd0, 1, 0));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Timeout with HOLD_MAX=4: 0 and 1 alternate every 4 cycles.
    step(mk(1, 1, 8'h00, 8'h00, 3'd0, 0, 0), "to rst");
    for (int i = 0; i < 4; i++) step(mk(1, 0, 8'h03, 8'h01, 3'd0, 1, 0), $sformatf("to own0 c%0d", i));
    step(mk(1, 0, 8'h03, 8'h02, 3'd1, 1, 1), "to revoke0");
    for (int i = 0; i < 3; i++) step(mk(1, 0, 8'h03, 8'h02, 3'd1, 1, 0), $sformatf("to own1 c%0d", i));
    step(mk(1, 0, 8'h03, 8'h01, 3'd0, 1, 1), "to revoke1");

    // Lone holder is revoked to idle (masked), then re-granted.
    step(mk(1, 1, 8'h00, 8'h00, 3'd0, 0, 0), "lone rst");
    for (int i = 0; i < 4; i++) step(mk(1, 0, 8'h01, 8'h01, 3'd0, 1, 0), $sformatf("lone c%0d", i));
    step(mk(1, 0, 8'h01, 8'h00, 3'd0, 0, 1), "lone revoke");
    step(mk(1, 0, 8'h01, 8'h01, 3'd0, 1, 0), "lone regrant");

    // Release on the revoke cycle is a plain release.
    step(mk(1, 1, 8'h00, 8'h00, 3'd0, 0, 0), "relrev rst");
    for (int i = 0; i < 4; i++) step(mk(1, 0, 8'h03, 8'h01, 3'd0, 1, 0), $sformatf("relrev c%0d", i));
    step(mk(1, 0, 8'h02, 8'h02, 3'd1, 1, 0), "relrev handover");

    // Reset mid-grant.
    step(mk(0, 1, 8'h00, 8'h00, 3'd0, 0, 0), "midrst rst");
    step(mk(0, 0, 8'h20, 8'h20, 3'd5, 1, 0), "midrst grant");
    step(mk(0, 0, 8'h20, 8'h20, 3'd5, 1, 0), "midrst hold");
    step(mk(0, 1, 8'h20, 8'h00, 3'd0, 0, 0), "midrst pulse");
    step(mk(0, 0, 8'h20, 8'h20, 3'd5, 1, 0), "midrst regrant");

    // Random traffic on both instances against the model.
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      rr = (c == 0) || ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 5))
        0: cur = 8'($urandom);
        1: cur = 8'($urandom) & 8'($urandom);
        2: cur = cur & ~8'(1 << $urandom_range(0, 7));
        default: ;
      endcase
      rst_a = rr; rst_b = rr; req_a = cur; req_b = cur;
      model_edge(0, rr, cur);
      model_edge(1, rr, cur);
      @(posedge clk); #1;
      cmp_model(0, gnt_a, id_a, v_a, to_a);
      cmp_model(1, gnt_b, id_b, v_b, to_b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
